serial_adder_ctrl: RTL

- Bit-serial multi-bit adder built around the team's existing 1-bit full-adder cell (adder1), with one instance of that cell.
- Latches two WIDTH-bit operands and a carry-in, then feeds the cell one bit pair per clock, LSB first.
- Registers the cell's carry-out back into its carry-in and shifts the cell's sum into a result register.
- Acts as the sequencing stage directly upstream and downstream of adder1: it feeds A/B/CI and consumes SUM/CO.

---
 rtl/serial_adder_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one adder1 cell LSB-first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module adder1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits already produced; the final bit comes straight from the cell.
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_sum;
  logic             cell_co;
  logic             last;
  logic             accept;

  adder1 u_adder1 (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .ci  (carry),
    .sum (cell_sum),
    .co  (cell_co)
  );

  assign accept   = (state == IDLE) && start;
  assign last     = (cnt == CW'(WIDTH - 1));
  assign sum_next = {cell_sum, sum_sh};
  assign busy     = (state == RUN);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: default assignment first keeps this purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand/partial-sum shift registers are plain flops, not a memory, so they reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= cell_co;
        sum_sh <= sum_next[WIDTH-1:1];
        cnt    <= cnt + CW'(1);
        if (last) begin
          sum  <= sum_next;
          cout <= cell_co;
          done <= 1'b1;
          cnt  <= '0;
`ifdef SERIAL_ADD_OVF_EN
          // carry still holds the carry into the MSB; cell_co is the carry out of it.
          ovf  <= carry ^ cell_co;
`endif
        end
      end
    end
  end

endmodule
